// File: rtl/apb_slave_regfile.sv
// APB completer with a small bank of byte-strobed registers, a fixed number of
// wait states and an error response for illegal accesses.
module apb_slave_regfile #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    REG_NUM     = 16,
   parameter int                    WAIT_CYCLES = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001,
   parameter bit                    PRIV_WRITE  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [2:0]              pprot,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);

   localparam int                    BYTES      = DATA_WIDTH / 8;
   localparam int                    LSB        = $clog2(BYTES);
   localparam int                    IDX_W      = $clog2(REG_NUM);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] REG_LIMIT  = ADDR_WIDTH'(REG_NUM);
   localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES);
   localparam bit                    NO_WAIT    = (WAIT_CYCLES == 0);

   typedef enum logic {
      S_IDLE,
      S_ACCESS
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [DATA_WIDTH-1:0] r_regs [REG_NUM];

   logic [IDX_W-1:0]      r_idx;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [BYTES-1:0]      r_strb;
   logic                  r_err;

   logic [3:0]            r_cnt;
   logic                  r_pready;
   logic                  r_pslverr;
   logic [DATA_WIDTH-1:0] r_prdata;

   logic [ADDR_WIDTH-1:0] w_off;
   logic [ADDR_WIDTH-1:0] w_word;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_range_err;
   logic                  w_wr_err;
   logic                  w_err;
   logic                  w_setup;
   logic                  w_abort;
   logic                  w_done;
   logic                  w_tick;
   logic                  w_commit;
   logic                  w_unused_prot;

   // Register 0 is the fixed ID; the array slot behind it is never written.
   function automatic logic [DATA_WIDTH-1:0] f_read(input logic [IDX_W-1:0] idx);
      if (idx == '0) begin
         return ID_VALUE;
      end
      return r_regs[idx];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] f_merge(
      input logic [DATA_WIDTH-1:0] old_val,
      input logic [DATA_WIDTH-1:0] new_val,
      input logic [BYTES-1:0]      strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_val;
      for (int i = 0; i < BYTES; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return res;
   endfunction

   assign w_off         = paddr - BASE_ADDR;
   assign w_word        = w_off >> LSB;
   assign w_idx         = w_word[IDX_W-1:0];
   assign w_range_err   = (paddr < BASE_ADDR) || (w_word >= REG_LIMIT) ||
                          (|(paddr & ALIGN_MASK));
   assign w_wr_err      = pwrite && ((w_idx == '0) || (PRIV_WRITE && !pprot[0]));
   assign w_err         = w_range_err || w_wr_err;
   assign w_unused_prot = &{1'b0, pprot[2:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Abort takes priority over completion and wait-state counting.
   always_comb begin
      w_state_nxt = r_state;
      w_setup     = 1'b0;
      w_abort     = 1'b0;
      w_done      = 1'b0;
      w_tick      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (psel && !penable) begin
               w_setup     = 1'b1;
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!psel) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (penable && r_pready) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt != 4'd0) begin
               w_tick      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_commit = w_done && r_write && !r_err;

   always_ff @(posedge clk) begin
      if (w_setup) begin
         r_idx   <= w_idx;
         r_write <= pwrite;
         r_wdata <= pwdata;
         r_strb  <= pstrb;
         r_err   <= w_err;
      end
   end

   // prdata is loaded at setup and refreshed when pready rises, so a read
   // returns the register contents as they stand at completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 4'd0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else if (w_setup) begin
         r_cnt     <= WAIT_LOAD;
         r_pready  <= NO_WAIT;
         r_pslverr <= NO_WAIT ? w_err : 1'b0;
         r_prdata  <= (!pwrite && !w_err) ? f_read(w_idx) : '0;
      end else if (w_abort || w_done) begin
         r_cnt     <= 4'd0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else if (w_tick) begin
         r_cnt <= r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= (!r_write && !r_err) ? f_read(r_idx) : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[r_idx] <= f_merge(r_regs[r_idx], r_wdata, r_strb);
      end
   end

   assign prdata  = r_prdata;
   assign pready  = r_pready;
   assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a WAIT_CYCLES=2 instance (a) and a
// WAIT_CYCLES=0 instance (b) share the bus signals but have separate selects.
module tb_apb_slave_regfile;

   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] paddr;
   logic        psel_a, psel_b, penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] rd;
   logic        er;
   int          nw;

   always #5 clk = ~clk;

   apb_slave_regfile #(.WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_a), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
   );

   apb_slave_regfile #(.WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_b), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
   );

   // nwait = access cycles seen before pready, -1 if pready never came.
   task automatic apb_xfer(input bit use_b, input bit no_idle, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot,
                           output logic [31:0] rdata, output logic err, output int nwait);
      if (!no_idle) begin
         @(posedge clk); #1;
      end
      psel_a = !use_b; psel_b = use_b; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
      @(posedge clk); #1;
      penable = 1'b1;
      nwait = 0;
      @(negedge clk);
      while (!(use_b ? pready_b : pready_a) && nwait < 40) begin
         nwait++;
         @(negedge clk);
      end
      if (nwait >= 40) nwait = -1;
      rdata = use_b ? prdata_b : prdata_a;
      err   = use_b ? pslverr_b : pslverr_a;
      @(posedge clk); #1;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      @(negedge clk);
      checks++; if ({prdata_a, pready_a, pslverr_a} !== 34'd0) begin errors++;
         $display("FAIL rst_outputs got=%h/%b/%b exp=0/0/0", prdata_a, pready_a, pslverr_a); end
      @(posedge clk); #1 rst = 1'b0;
      apb_xfer(0, 0, 0, 32'h00, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if (rd !== ID) begin errors++; $display("FAIL rd_reg0 got=%h exp=%h", rd, ID); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_reg0_err got=%b exp=0", er); end
      checks++; if (nw !== 2) begin errors++; $display("FAIL rd_reg0_lat got=%0d exp=2", nw); end
      apb_xfer(0, 0, 0, 32'h14, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if ({rd, er} !== 33'd0) begin errors++;
         $display("FAIL rd_reg5 got=%h/%b exp=0/0", rd, er); end
   endtask

   task automatic test_write_strobe();
      apb_xfer(0, 0, 1, 32'h0C, 32'h1234_5678, 4'hF, 3'b001, rd, er, nw);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_reg3_err got=%b exp=0", er); end
      checks++; if (nw !== 2) begin errors++; $display("FAIL wr_reg3_lat got=%0d exp=2", nw); end
      checks++; if ({prdata_a, pready_a, pslverr_a} !== 34'd0) begin errors++;
         $display("FAIL post_done_clear got=%h/%b/%b exp=0/0/0", prdata_a, pready_a, pslverr_a); end
      apb_xfer(0, 0, 0, 32'h0C, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if (rd !== 32'h1234_5678) begin errors++;
         $display("FAIL rd_reg3 got=%h exp=12345678", rd); end
      apb_xfer(0, 0, 1, 32'h0C, 32'hFFFF_FFFF, 4'b0010, 3'b001, rd, er, nw);
      apb_xfer(0, 0, 0, 32'h0C, '0, 4'hF, 3'b000, rd, er, nw);
      checks++; if (rd !== 32'h1234_FF78) begin errors++;
         $display("FAIL rd_reg3_strb got=%h exp=1234ff78", rd); end
   endtask

   task automatic test_errors();
      apb_xfer(0, 0, 0, 32'h40, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if ({rd, er} !== {32'd0, 1'b1}) begin errors++;
         $display("FAIL rd_oor got=%h/%b exp=0/1", rd, er); end
      checks++; if (nw !== 2) begin errors++; $display("FAIL rd_oor_lat got=%0d exp=2", nw); end
      apb_xfer(0, 0, 0, 32'h06, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if ({rd, er} !== {32'd0, 1'b1}) begin errors++;
         $display("FAIL rd_misalign got=%h/%b exp=0/1", rd, er); end
      apb_xfer(0, 0, 1, 32'h00, 32'hDEAD_BEEF, 4'hF, 3'b001, rd, er, nw);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr_reg0_err got=%b exp=1", er); end
      apb_xfer(0, 0, 0, 32'h00, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if ({rd, er} !== {ID, 1'b0}) begin errors++;
         $display("FAIL rd_reg0_after got=%h/%b exp=%h/0", rd, er, ID); end
      apb_xfer(0, 0, 0, 32'h3C, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if ({rd, er} !== 33'd0) begin errors++;
         $display("FAIL rd_last_reg got=%h/%b exp=0/0", rd, er); end
   endtask

   task automatic test_priv();
      apb_xfer(0, 0, 1, 32'h08, 32'h55, 4'hF, 3'b000, rd, er, nw);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr_unpriv_err got=%b exp=1", er); end
      apb_xfer(0, 0, 1, 32'h08, 32'h66, 4'hF, 3'b110, rd, er, nw);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr_prot110_err got=%b exp=1", er); end
      apb_xfer(0, 0, 0, 32'h08, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_reg2_unch got=%h exp=0", rd); end
      apb_xfer(0, 0, 1, 32'h08, 32'h55, 4'hF, 3'b001, rd, er, nw);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_priv_err got=%b exp=0", er); end
      apb_xfer(0, 0, 0, 32'h08, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if (rd !== 32'h55) begin errors++; $display("FAIL rd_reg2 got=%h exp=55", rd); end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 4; k++) begin
         apb_xfer(1, k != 1, 1, 32'(4 * k), 32'h1111_1111 * k, 4'hF, 3'b001, rd, er, nw);
         checks++; if (nw !== 0 || er !== 1'b0) begin errors++;
            $display("FAIL b2b_wr%0d lat/err got=%0d/%b exp=0/0", k, nw, er); end
      end
      for (int k = 1; k <= 4; k++) begin
         apb_xfer(1, 1, 0, 32'(4 * k), '0, 4'h0, 3'b000, rd, er, nw);
         checks++; if (rd !== 32'h1111_1111 * k || nw !== 0) begin errors++;
            $display("FAIL b2b_rd%0d got=%h/%0d exp=%h/0", k, rd, nw, 32'h1111_1111 * k); end
      end
   endtask

   task automatic test_reset_abort();
      // reset while a read of reg3 is waiting
      @(posedge clk); #1;
      psel_a = 1; penable = 0; pwrite = 0; paddr = 32'h0C; pstrb = 4'h0; pprot = 3'b000;
      @(posedge clk); #1 penable = 1;
      @(negedge clk);
      checks++; if (prdata_a !== 32'h1234_FF78 || pready_a !== 1'b0) begin errors++;
         $display("FAIL wait_prdata got=%h/%b exp=1234ff78/0", prdata_a, pready_a); end
      rst = 1'b1; #1;
      checks++; if ({prdata_a, pready_a, pslverr_a} !== 34'd0) begin errors++;
         $display("FAIL async_rst got=%h/%b/%b exp=0/0/0", prdata_a, pready_a, pslverr_a); end
      @(posedge clk); #1;
      psel_a = 0; penable = 0; rst = 1'b0;
      apb_xfer(0, 0, 0, 32'h0C, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if ({rd, er} !== 33'd0) begin errors++;
         $display("FAIL rd_reg3_postrst got=%h/%b exp=0/0", rd, er); end
      // reset during a wait state of a write to reg6
      @(posedge clk); #1;
      psel_a = 1; penable = 0; pwrite = 1; paddr = 32'h18; pwdata = 32'h6666_6666;
      pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk); #1 penable = 1;
      @(negedge clk);
      rst = 1'b1; #1;
      checks++; if ({prdata_a, pready_a, pslverr_a} !== 34'd0) begin errors++;
         $display("FAIL rst_wr_outputs got=%h/%b/%b exp=0/0/0", prdata_a, pready_a, pslverr_a); end
      @(posedge clk); #1;
      psel_a = 0; penable = 0; rst = 1'b0;
      apb_xfer(0, 0, 0, 32'h18, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if (rd !== 32'h0 || nw !== 2) begin errors++;
         $display("FAIL rd_reg6 got=%h/%0d exp=0/2", rd, nw); end
      // abort: psel dropped after one access cycle of a write to reg7
      @(posedge clk); #1;
      psel_a = 1; penable = 0; pwrite = 1; paddr = 32'h1C; pwdata = 32'h7777_7777;
      pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk); #1 penable = 1;
      @(posedge clk); #1;
      psel_a = 0; penable = 0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (pready_a !== 1'b0) begin errors++;
         $display("FAIL abort_pready got=%b exp=0", pready_a); end
      apb_xfer(0, 0, 0, 32'h1C, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if ({rd, er} !== 33'd0 || nw !== 2) begin errors++;
         $display("FAIL rd_reg7_abort got=%h/%b/%0d exp=0/0/2", rd, er, nw); end
      apb_xfer(0, 0, 1, 32'h1C, 32'h7777_7777, 4'hF, 3'b001, rd, er, nw);
      apb_xfer(0, 0, 0, 32'h1C, '0, 4'h0, 3'b000, rd, er, nw);
      checks++; if (rd !== 32'h7777_7777) begin errors++;
         $display("FAIL rd_reg7 got=%h exp=77777777", rd); end
   endtask

   initial begin
      test_reset();
      test_write_strobe();
      test_errors();
      test_priv();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
